// File: rtl/adc_mon_pkg.sv
// Shared types and defaults for the ADC temperature monitor.
// Channel 17 carries the on-die temperature sensor.
package adc_mon_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        COLD = 2'd1,
        HOT  = 2'd2
    } mon_state_t;

    localparam int ADC_W         = 12;
    localparam int ADC_CH_W      = 5;
    localparam int TSD_CHANNEL   = 17;
    localparam int THRESH_HI_DEF = 3643;
    localparam int THRESH_LO_DEF = 3600;

endpackage

// File: rtl/adc_block_avg.sv
// Picks one channel out of the ADC response stream and emits the truncated
// mean of every block of 2^AVG_LOG2 accepted samples.
module adc_block_avg
    import adc_mon_pkg::*;
#(
    parameter int DATA_W   = ADC_W,
    parameter int CH_W     = ADC_CH_W,
    parameter int CHANNEL  = TSD_CHANNEL,
    parameter int AVG_LOG2 = 3
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_channel,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    output logic              avg_valid,
    output logic [DATA_W-1:0] avg_data
);

    // Wide enough for a full block of max-scale samples, so no overflow.
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam logic [CH_W-1:0]     CH_SEL   = CH_W'(CHANNEL);
    localparam logic [AVG_LOG2-1:0] IDX_LAST = '1;

    logic [ACC_W-1:0]    acc_reg;
    logic [ACC_W-1:0]    acc_sum;
    logic [AVG_LOG2-1:0] idx_reg;
    logic                avg_valid_reg;
    logic [DATA_W-1:0]   avg_data_reg;
    logic                accept;

    assign accept  = in_valid && (in_channel == CH_SEL);
    assign acc_sum = acc_reg + ACC_W'(in_data);

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            acc_reg       <= '0;
            idx_reg       <= '0;
            avg_valid_reg <= 1'b0;
            avg_data_reg  <= '0;
        end else begin
            avg_valid_reg <= 1'b0;
            if (clear) begin
                // avg_data deliberately keeps the last completed average.
                acc_reg <= '0;
                idx_reg <= '0;
            end else if (accept) begin
                if (idx_reg == IDX_LAST) begin
                    avg_data_reg  <= acc_sum[ACC_W-1:AVG_LOG2];
                    avg_valid_reg <= 1'b1;
                    acc_reg       <= '0;
                    idx_reg       <= '0;
                end else begin
                    acc_reg <= acc_sum;
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end

    assign avg_valid = avg_valid_reg;
    assign avg_data  = avg_data_reg;

endmodule

// File: rtl/adc_temp_monitor.sv
// Filtered over-temperature detector: block average of one ADC channel fed
// through a hysteresis comparator, with a saturating count of COLD->HOT events.
module adc_temp_monitor
    import adc_mon_pkg::*;
#(
    parameter int DATA_W    = ADC_W,
    parameter int CH_W      = ADC_CH_W,
    parameter int CHANNEL   = TSD_CHANNEL,
    parameter int AVG_LOG2  = 3,
    parameter int THRESH_HI = THRESH_HI_DEF,
    parameter int THRESH_LO = THRESH_LO_DEF,
    parameter int CNT_W     = 8
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_channel,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    output logic              avg_valid,
    output logic [DATA_W-1:0] avg_data,
    output logic              hot,
    output logic              hot_rise,
    output logic [CNT_W-1:0]  event_count
);

    localparam logic [DATA_W-1:0] HI_V = DATA_W'(THRESH_HI);
    localparam logic [DATA_W-1:0] LO_V = DATA_W'(THRESH_LO);

    mon_state_t       state_reg, state_next;
    logic             rise_reg, rise_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             above_hi, below_lo;

    adc_block_avg #(
        .DATA_W   (DATA_W),
        .CH_W     (CH_W),
        .CHANNEL  (CHANNEL),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk_in     (clk_in),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_channel (in_channel),
        .in_data    (in_data),
        .clear      (clear),
        .avg_valid  (avg_valid),
        .avg_data   (avg_data)
    );

    assign above_hi = avg_data > HI_V;
    assign below_lo = avg_data < LO_V;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_reg <= INIT;
            rise_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            rise_reg  <= rise_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rise_next  = 1'b0;
        count_next = count_reg;
        if (clear) begin
            state_next = INIT;
            count_next = '0;
        end else if (avg_valid) begin
            case (state_reg)
                // Starting hot is not an event: there was no cold reading to leave.
                INIT: state_next = above_hi ? HOT : COLD;
                COLD: begin
                    if (above_hi) begin
                        state_next = HOT;
                        rise_next  = 1'b1;
                        if (count_reg != '1) count_next = count_reg + 1'b1;
                    end
                end
                HOT: begin
                    if (below_lo) state_next = COLD;
                end
                default: state_next = INIT;
            endcase
        end
    end

    assign hot         = (state_reg == HOT);
    assign hot_rise    = rise_reg;
    assign event_count = count_reg;

endmodule
